// File: rtl/rotate_right_seq_if.sv
// Operand/result handshake bundle for the iterative right rotator.
// slave = the rotator side, master = the producer/consumer side.
interface rotate_right_seq_if #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in;
    logic [SHAMT_W-1:0] shamt;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out;
    logic               busy;

    modport slave (
        input  in_valid,
        input  in,
        input  shamt,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out,
        output busy
    );

    modport master (
        output in_valid,
        output in,
        output shamt,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out,
        input  busy
    );
endinterface

// File: rtl/rotate_right_seq.sv
// Iterative rotate-right, one bit per clock: result valid k = shamt mod WIDTH edges after acceptance.
// One op in flight; in_ready only in IDLE; the result is held in DONE until out_ready.
module rotate_right_seq #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 5,
    parameter int CNT_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    rotate_right_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ROTATE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [WIDTH-1:0] out_q,   out_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic [CNT_W-1:0] k_amt;
    logic [WIDTH-1:0] data_ror;
    logic             accept;
    logic             last_step;

    // Only the low CNT_W bits matter: shamt >= WIDTH wraps, never zero-fills.
    assign k_amt     = bus.shamt[CNT_W-1:0];
    assign data_ror  = {data_q[0], data_q[WIDTH-1:1]};
    assign accept    = (state_q == S_IDLE) && bus.in_valid;
    assign last_step = (state_q == S_ROTATE) && (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    data_d = bus.in;
                    cnt_d  = k_amt;
                    if (k_amt == '0) begin
                        out_d   = bus.in;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ROTATE;
                    end
                end
            end
            S_ROTATE: begin
                data_d = data_ror;
                cnt_d  = cnt_q - CNT_W'(1);
                // out only changes on entry to DONE so it holds the last result in between.
                if (last_step) begin
                    out_d   = data_ror;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
            end
            S_ROTATE: begin
                bus.in_ready = 1'b0;
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
            end
            default: begin
                bus.in_ready = 1'b0;
            end
        endcase
    end

    assign bus.out = out_q;

    a_out_held: assert property (@(posedge clk) disable iff (rst)
        (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.out)));

    a_no_overlap: assert property (@(posedge clk) disable iff (rst)
        !(bus.in_ready && bus.out_valid));

endmodule

// File: tb/tb_rotate_right_seq.sv
// Self-checking bench for rotate_right_seq: directed cases, async reset mid-op, full in x shamt sweep.
module tb_rotate_right_seq;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    rotate_right_seq_if #(.WIDTH(8), .SHAMT_W(5)) bus ();

    rotate_right_seq #(.WIDTH(8), .SHAMT_W(5), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain arithmetic rotate-right of an 8-bit value by shamt mod 8.
    function automatic logic [31:0] ref_rotr(input int v, input int s);
        int k;
        k = s % 8;
        return ((v >> k) | (v << (8 - k))) & 255;
    endfunction

    // Runs one operation starting at a negedge. After acceptance the inputs are
    // replaced by junk (jd/js/jv) to show they are sampled only at acceptance.
    task automatic do_op(input logic [7:0] d, input logic [4:0] s, input int stall,
                         input logic [7:0] jd, input logic [4:0] js, input logic jv);
        int          lat;
        int          bsy;
        int          guard;
        int          k;
        logic [31:0] exp;
        k     = s % 8;
        exp   = ref_rotr(int'(d), int'(s));
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            check("idle_timeout", 32'(bus.in_ready), 32'd1);
            return;
        end
        bus.in_valid  = 1'b1;
        bus.in        = d;
        bus.shamt     = s;
        bus.out_ready = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = jv;
        bus.in       = jd;
        bus.shamt    = js;
        lat = 0;
        bsy = 0;
        while (!bus.out_valid && lat < 40) begin
            check("rot_in_ready", 32'(bus.in_ready), 32'd0);
            if (bus.busy) bsy++;
            bus.out_ready = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) begin
            check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
            return;
        end
        check("latency", 32'(lat), 32'(k));
        check("out", 32'(bus.out), exp);
        for (int i = 0; i < stall; i++) begin
            bus.out_ready = 1'b0;
            if (bus.busy) bsy++;
            @(posedge clk);
            @(negedge clk);
            check("stall_vld", 32'(bus.out_valid), 32'd1);
            check("stall_out", 32'(bus.out), exp);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        if (bus.busy) bsy++;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("vld_drop", 32'(bus.out_valid), 32'd0);
        check("ready_back", 32'(bus.in_ready), 32'd1);
        check("out_hold", 32'(bus.out), exp);
        check("busy_cycles", 32'(bsy), 32'(k + 1 + stall));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in        = '0;
        bus.shamt     = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_out",       32'(bus.out),       32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(8'hB1, 5'd3,  0, 8'h00, 5'd0, 1'b0);
        do_op(8'h5A, 5'd0,  0, 8'hC3, 5'd5, 1'b0);
        do_op(8'h5A, 5'd8,  0, 8'h11, 5'd1, 1'b0);
        do_op(8'hB1, 5'd11, 0, 8'h22, 5'd2, 1'b0);
        do_op(8'h01, 5'd7,  0, 8'h33, 5'd3, 1'b0);

        // Held result under backpressure while a new op (0xFF) is already waiting.
        do_op(8'hB1, 5'd3, 5, 8'hFF, 5'd2, 1'b1);
        do_op(8'hFF, 5'd2, 0, 8'h00, 5'd0, 1'b0);

        // Asynchronous reset between clock edges, two edges into ROTATE.
        bus.in_valid = 1'b1;
        bus.in       = 8'h80;
        bus.shamt    = 5'd7;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_out",       32'(bus.out),       32'd0);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_in_ready",  32'(bus.in_ready),  32'd1);
        check("arst_busy",      32'(bus.busy),      32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        do_op(8'h80, 5'd1, 0, 8'h00, 5'd0, 1'b0);

        // Every operand x every shamt, in a scrambled order with random stalls.
        for (int i = 0; i < 8192; i++) begin
            int          idx;
            int          stall;
            logic [12:0] v;
            idx   = (i * 2731 + 97) % 8192;
            v     = 13'(idx);
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            if ($urandom_range(0, 7) == 0) @(negedge clk);
            do_op(v[7:0], v[12:8], stall, 8'($urandom), 5'($urandom), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
